// File: rtl/lookup_table_ctrl.sv
// -----------------------------------------------------------------------------
// lookup_table_ctrl
//
// Port-A sequencer for the writeable look-up table. It arbitrates the table's
// update port between two users: host single-word reads and writes over a
// valid/ready handshake, and a bulk-clear engine that fills every entry with a
// programmable word. Port B of the table (the look-up side) is not touched.
//
// Ports:
//   clk          single clock, also the table's a_clk
//   rst          synchronous, active-high reset
//   clear_start  one-cycle pulse requesting a bulk clear
//   clear_value  fill word, sampled when clear_start is accepted
//   clear_busy   high while a clear is pending or running
//   clear_done   one-cycle pulse when a clear completes
//   req_valid    host request valid
//   req_ready    host request accepted when req_valid && req_ready
//   req_we       1 = write, 0 = read
//   req_addr     host word address
//   req_wdata    host write data
//   resp_valid   one-cycle pulse, read data valid
//   resp_rdata   read data, held until the next response
//   tbl_addr     table a_addr (registered)
//   tbl_din      table a_din  (registered)
//   tbl_we       table a_we   (registered)
//   tbl_dout     table a_dout, valid one cycle after the address is presented
// -----------------------------------------------------------------------------
module lookup_table_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_start,
    input  logic [DATA_BITS-1:0] clear_value,
    output logic                 clear_busy,
    output logic                 clear_done,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic [ADDR_BITS-1:0] tbl_addr,
    output logic [DATA_BITS-1:0] tbl_din,
    output logic                 tbl_we,
    input  logic [DATA_BITS-1:0] tbl_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    // One extra counter bit so that "all DEPTH entries written" is a distinct
    // value rather than a wrap back to zero.
    localparam logic [ADDR_BITS:0] CNT_END = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS + 1)'(1);

    state_t               state_q, state_nxt;
    logic [ADDR_BITS:0]   cnt_q, cnt_nxt;
    logic                 pend_q, pend_nxt;
    logic [DATA_BITS-1:0] fill_q, fill_nxt;

    logic [ADDR_BITS-1:0] tbl_addr_nxt;
    logic [DATA_BITS-1:0] tbl_din_nxt;
    logic                 tbl_we_nxt;
    logic                 resp_valid_nxt;
    logic [DATA_BITS-1:0] resp_rdata_nxt;
    logic                 clear_busy_nxt;
    logic                 clear_done_nxt;

    // A clear request (new or pending) always wins over a host request in IDLE.
    assign req_ready = (state_q == IDLE) && !pend_q && !clear_start;

    always_comb begin
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;
        pend_nxt       = pend_q;
        fill_nxt       = fill_q;
        tbl_addr_nxt   = tbl_addr;
        tbl_din_nxt    = tbl_din;
        tbl_we_nxt     = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata;
        clear_busy_nxt = clear_busy;
        clear_done_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q || clear_start) begin
                    // A pending clear already owns its latched fill word; a
                    // fresh request takes clear_value. First write (addr 0)
                    // goes out in the next cycle.
                    fill_nxt       = pend_q ? fill_q : clear_value;
                    pend_nxt       = 1'b0;
                    state_nxt      = CLEAR;
                    tbl_we_nxt     = 1'b1;
                    tbl_addr_nxt   = '0;
                    tbl_din_nxt    = pend_q ? fill_q : clear_value;
                    cnt_nxt        = CNT_ONE;
                    clear_busy_nxt = 1'b1;
                end else if (req_valid) begin
                    tbl_addr_nxt = req_addr;
                    if (req_we) begin
                        tbl_we_nxt  = 1'b1;
                        tbl_din_nxt = req_wdata;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end

            RD_ADDR: begin
                state_nxt = RD_DATA;
                if (clear_start && !pend_q) begin
                    pend_nxt       = 1'b1;
                    fill_nxt       = clear_value;
                    clear_busy_nxt = 1'b1;
                end
            end

            RD_DATA: begin
                resp_rdata_nxt = tbl_dout;
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
                if (clear_start && !pend_q) begin
                    pend_nxt       = 1'b1;
                    fill_nxt       = clear_value;
                    clear_busy_nxt = 1'b1;
                end
            end

            CLEAR: begin
                if (cnt_q == CNT_END) begin
                    state_nxt      = IDLE;
                    cnt_nxt        = '0;
                    clear_busy_nxt = 1'b0;
                    clear_done_nxt = 1'b1;
                end else begin
                    tbl_we_nxt   = 1'b1;
                    tbl_addr_nxt = cnt_q[ADDR_BITS-1:0];
                    tbl_din_nxt  = fill_q;
                    cnt_nxt      = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            tbl_addr   <= '0;
            tbl_din    <= '0;
            tbl_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            pend_q     <= pend_nxt;
            tbl_addr   <= tbl_addr_nxt;
            tbl_din    <= tbl_din_nxt;
            tbl_we     <= tbl_we_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            clear_busy <= clear_busy_nxt;
            clear_done <= clear_done_nxt;
        end
    end

    // Fill word is pure data; it is always rewritten before it is used.
    always_ff @(posedge clk) begin
        fill_q <= fill_nxt;
    end

endmodule

// File: tb/tb_lookup_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lookup_table_ctrl
//
// Bench for lookup_table_ctrl with DEPTH=16. A behavioural synchronous table
// sits on port A; a transaction-level array mem_ref holds what each entry must
// contain after every completed host write or clear.
// -----------------------------------------------------------------------------
module tb_lookup_table_ctrl;

    localparam int DEPTH     = 16;
    localparam int DATA_BITS = 32;
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clear_start = 1'b0;
    logic [DATA_BITS-1:0] clear_value = '0;
    logic                 clear_busy;
    logic                 clear_done;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_we = 1'b0;
    logic [ADDR_BITS-1:0] req_addr = '0;
    logic [DATA_BITS-1:0] req_wdata = '0;
    logic                 resp_valid;
    logic [DATA_BITS-1:0] resp_rdata;
    logic [ADDR_BITS-1:0] tbl_addr;
    logic [DATA_BITS-1:0] tbl_din;
    logic                 tbl_we;
    logic [DATA_BITS-1:0] tbl_dout;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic [DATA_BITS-1:0] tbl_mem [DEPTH];
    logic [DATA_BITS-1:0] mem_ref [DEPTH];

    always #5 clk = ~clk;

    lookup_table_ctrl #(
        .DEPTH    (DEPTH),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_start(clear_start),
        .clear_value(clear_value),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .tbl_addr   (tbl_addr),
        .tbl_din    (tbl_din),
        .tbl_we     (tbl_we),
        .tbl_dout   (tbl_dout)
    );

    // Synchronous single-port table: read data one cycle after the address.
    always @(posedge clk) begin
        if (tbl_we) tbl_mem[tbl_addr] <= tbl_din;
        tbl_dout <= tbl_mem[tbl_addr];
    end

    always @(negedge clk) begin
        if (tbl_we) we_count++;
    end

    function automatic logic [63:0] pk(input logic we, input logic busy, input logic done,
                                       input logic rv, input logic [ADDR_BITS-1:0] a,
                                       input logic [DATA_BITS-1:0] d);
        return {we, busy, done, rv, 28'(a), d};
    endfunction

    function automatic logic [63:0] obs_pk();
        return pk(tbl_we, clear_busy, clear_done, resp_valid, tbl_addr, tbl_din);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with the request already driven; returns at
    // posedge+2 of the cycle in which req_ready is high (or after the budget).
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check(tag, 64'(req_ready), 64'd1);
    endtask

    task automatic host_write(input logic [ADDR_BITS-1:0] a, input logic [DATA_BITS-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        wait_ready("wr_ready");
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wr_drive", obs_pk(), pk(1'b1, 1'b0, 1'b0, 1'b0, a, d));
        mem_ref[a] = d;
    endtask

    task automatic host_read(input logic [ADDR_BITS-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready("rd_ready");
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rd_addr", {tbl_we, resp_valid, 28'(tbl_addr)}, {1'b0, 1'b0, 28'(a)});
        @(posedge clk); #1;
        check("rd_wait", {tbl_we, resp_valid}, 2'b00);
        @(posedge clk); #1;
        check("rd_resp_valid", {tbl_we, resp_valid}, 2'b01);
        check("rd_rdata", resp_rdata, mem_ref[a]);
        @(posedge clk); #1;
        check("rd_resp_pulse", resp_valid, 1'b0);
    endtask

    // Entered at posedge+1 of the cycle presenting address 0; returns at
    // posedge+1 of the clear_done cycle.
    task automatic sweep(input logic [DATA_BITS-1:0] v);
        for (int k = 0; k < DEPTH; k++) begin
            check("clear_sweep", obs_pk(), pk(1'b1, 1'b1, 1'b0, 1'b0, ADDR_BITS'(k), v));
            @(posedge clk); #1;
        end
        check("clear_end", {tbl_we, clear_busy, clear_done}, 3'b001);
        for (int i = 0; i < DEPTH; i++) mem_ref[i] = v;
    endtask

    task automatic pulse_clear(input logic [DATA_BITS-1:0] v);
        clear_start = 1'b1; clear_value = v;
        #1;
        check("clr_blocks_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        clear_start = 1'b0;
    endtask

    initial begin
        logic [DATA_BITS-1:0] v, d;
        logic [ADDR_BITS-1:0] a;
        int we0, done_seen, busy_seen, r;

        for (int i = 0; i < DEPTH; i++) mem_ref[i] = '0;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", obs_pk(), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // ---- write then read addr 5 ----
        we0 = we_count;
        host_write(ADDR_BITS'(5), 32'h1234_5678);
        host_read(ADDR_BITS'(5));
        check("wr5_we_once", 64'(we_count - we0), 64'd1);

        // ---- four back-to-back writes, req_valid held ----
        we0 = we_count;
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = ADDR_BITS'(i); req_wdata = 32'hA0 + 32'(i);
            #1;
            check("b2b_ready", 64'(req_ready), 64'd1);
            if (i > 0)
                check("b2b_drive", obs_pk(),
                      pk(1'b1, 1'b0, 1'b0, 1'b0, ADDR_BITS'(i - 1), 32'hA0 + 32'(i - 1)));
            @(posedge clk); #1;
            mem_ref[i] = 32'hA0 + 32'(i);
        end
        req_valid = 1'b0;
        check("b2b_drive_last", obs_pk(), pk(1'b1, 1'b0, 1'b0, 1'b0, ADDR_BITS'(3), 32'hA3));
        @(posedge clk); #1;
        check("b2b_we_count", 64'(we_count - we0), 64'd4);
        host_read(ADDR_BITS'(2));

        // ---- clear with zero ----
        pulse_clear('0);
        sweep('0);
        @(posedge clk); #1;
        check("clear_done_pulse", {clear_done, clear_busy}, 2'b00);
        host_read(ADDR_BITS'(2));
        host_read(ADDR_BITS'($urandom_range(0, DEPTH - 1)));

        // ---- clear_start and a write in the same IDLE cycle ----
        v = $urandom | 32'h1;
        d = $urandom;
        clear_start = 1'b1; clear_value = v;
        req_valid = 1'b1; req_we = 1'b1; req_addr = ADDR_BITS'(3); req_wdata = d;
        #1;
        check("clr_prio_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        sweep(v);
        host_write(ADDR_BITS'(3), d);
        host_read(ADDR_BITS'(3));
        host_read(ADDR_BITS'(4));

        // ---- clear_start one cycle after a read accept ----
        v = $urandom;
        req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_BITS'(3);
        wait_ready("rdclr_ready");
        @(posedge clk); #1;
        req_valid = 1'b0;
        clear_start = 1'b1; clear_value = v;
        check("rdclr_n1", {tbl_we, clear_busy, resp_valid}, 3'b000);
        @(posedge clk); #1;
        clear_start = 1'b0;
        check("rdclr_n2", {tbl_we, clear_busy, resp_valid}, 3'b010);
        @(posedge clk); #1;
        check("rdclr_n3", {tbl_we, clear_busy, resp_valid}, 3'b011);
        check("rdclr_rdata", resp_rdata, mem_ref[3]);
        @(posedge clk); #1;
        sweep(v);

        // ---- reset in the middle of a clear ----
        d = $urandom;
        host_write(ADDR_BITS'(10), d);
        v = ~d;
        pulse_clear(v);
        for (int k = 0; k < 8; k++) begin
            check("midclr_sweep", obs_pk(), pk(1'b1, 1'b1, 1'b0, 1'b0, ADDR_BITS'(k), v));
            if (k < 7) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midclr_rst_out", obs_pk(), 64'd0);
        check("midclr_rst_rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        done_seen = 0; busy_seen = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(posedge clk); #1;
            if (clear_done) done_seen++;
            if (clear_busy || tbl_we) busy_seen++;
        end
        check("midclr_no_done", 64'(done_seen), 64'd0);
        check("midclr_idle", 64'(busy_seen), 64'd0);
        for (int i = 0; i < 8; i++) mem_ref[i] = v;
        host_read(ADDR_BITS'(10));
        host_read(ADDR_BITS'(7));
        host_read(ADDR_BITS'(8));

        // ---- randomized traffic ----
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            a = ADDR_BITS'($urandom_range(0, DEPTH - 1));
            if (r < 5) begin
                host_write(a, $urandom);
            end else if (r < 9) begin
                host_read(a);
            end else begin
                v = $urandom;
                pulse_clear(v);
                sweep(v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
